drm_sync_fifo: RTL and testbench
================================

Name: drm_sync_fifo

Overview:
- Parametrised single-clock FIFO built on an inferred block-RAM array that maps onto DRM18K primitives (one or more, cascaded by width/depth).
- Successor to the fixed-geometry DRM18K wrapper: any data width and depth, with occupancy count, programmable almost-full/almost-empty thresholds and overflow/underflow flags.
- Used by the tsmac_phy datapath as the generic packet/byte buffer between MAC and PHY-side logic.

Parameters:
DATA_WIDTH, 18, width of each word in bits (1..72).
ADDR_WIDTH, 10, log2 of depth; DEPTH = 2**ADDR_WIDTH words.
AFULL_TH, 1020, almost_full asserts when count >= AFULL_TH.
AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH.

Ports:
clk  input  1  FIFO clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  write request.
wr_data  input  DATA_WIDTH  write data.
rd_en  input  1  read request (acknowledge in FWFT mode).
rd_data  output  DATA_WIDTH  read data.
rd_valid  output  1  rd_data carries a newly read word (standard mode).
full  output  1  no free entry.
empty  output  1  no readable word.
almost_full  output  1  count >= AFULL_TH.
almost_empty  output  1  count <= AEMPTY_TH.
count  output  ADDR_WIDTH+1  words stored, range 0..DEPTH.
overflow  output  1  one-cycle pulse: write rejected because full.
underflow  output  1  one-cycle pulse: read rejected because empty.

Behaviour:
- Reset is asynchronous and active-low; one clock domain. While rst_n=0: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. RAM contents are not cleared.
- Write accept: wr_acc = wr_en & !full. The word is stored at wptr, and wptr increments modulo DEPTH. Wrap-around is natural binary rollover.
- Read accept: rd_acc = rd_en & !empty. The word is read from rptr, and rptr increments modulo DEPTH.
- Accept is judged on the flags registered at the start of the cycle:
  - When full, a simultaneous read and write accepts only the read.
  - When empty, a simultaneous read and write accepts only the write.
- count next = count + wr_acc - rd_acc. All flags are registered and derived from count next, so they are valid in the cycle after the causing edge.
- full = (count == DEPTH); empty = (count == 0) in standard mode.
- overflow = wr_en & full; underflow = rd_en & empty. Both are registered, one-cycle pulses. They are not sticky.
- Standard mode read latency is 1:
  - rd_data and rd_valid=1 are presented on the cycle after rd_acc.
  - rd_valid=0 otherwise, and rd_data holds its last value.
- Read-during-write to the same address cannot occur in standard mode, because the read is blocked when empty.
- Thresholds are checked at elaboration: AEMPTY_TH < AFULL_TH <= DEPTH, otherwise $error.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight read data is discarded.

Optional Feature:
- Macro: DRM_SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - A one-entry prefetch/output register holds the head word, and rd_data shows it whenever empty=0.
  - rd_en acts as acknowledge: rd_acc = rd_en & !empty pops the head, and the next word is prefetched from RAM.
  - Back-to-back pops sustain one word per cycle while the RAM holds data.
  - empty reflects the output register. For a write to an empty FIFO at edge N, empty=0 and rd_data are valid after edge N+2.
  - count includes the word in the output register; full/almost flags keep their standard-mode definitions.
  - rd_valid = !empty.
- Undefined: standard mode as described in Behaviour, with no prefetch logic.

Test Plan:
- Reset, then write 0x00001..0x00004 and read 4 (standard mode, DATA_WIDTH=18, ADDR_WIDTH=4) -> rd_data 0x00001..0x00004, each with rd_valid one cycle after rd_en. count ends at 0 and empty=1.
- Fill with 16 writes (ADDR_WIDTH=4, AFULL_TH=14) -> almost_full=1 after the 14th write, full=1 and count=16 after the 16th. A 17th write gives overflow=1 for one cycle, and count stays 16.
- Full FIFO with wr_en=rd_en=1 -> read accepted, write rejected, count=15, overflow=1. Empty FIFO with wr_en=rd_en=1 -> write accepted, count=1, underflow=1.
- Stream 40 words through a 16-deep FIFO with continuous write and continuous read once count>=8 -> the pointers wrap twice and the output sequence is exactly 0..39 with no loss.
- Assert rst_n=0 mid-stream with count=9 -> outputs go to reset values asynchronously. After release, the first write/read of 0x2AAAA returns 0x2AAAA.
- FWFT_EN defined: write 0x12345 at edge N into an empty FIFO -> empty=0 and rd_data=0x12345 after edge N+2. Pulsing rd_en for one cycle gives empty=1 and count=0.

Source files
------------

// File: rtl/drm_sync_fifo.sv
// drm_sync_fifo: parametrised single-clock FIFO on an inferred block RAM with count,
// almost flags and overflow/underflow pulses. Define DRM_SYNC_FIFO_FWFT_EN for FWFT reads.
module drm_sync_fifo #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 10,
   parameter int AFULL_TH   = 1020,
   parameter int AEMPTY_TH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

   if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH) || DATA_WIDTH < 1 || DATA_WIDTH > 72)
   begin : g_bad_cfg
      $error("drm_sync_fifo: need AEMPTY_TH < AFULL_TH <= DEPTH and DATA_WIDTH in 1..72");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] ram_dout;

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  afull_q, afull_d, aempty_q, aempty_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  wr_acc, rd_acc, ram_rd;

   always_comb begin
      wr_acc   = wr_en & ~full_q;
      rd_acc   = rd_en & ~empty_q;
      wptr_d   = wptr_q + ADDR_WIDTH'(wr_acc);
      count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      full_d   = (count_d == DEPTH_C);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
      ovf_d    = wr_en & full_q;
      unf_d    = rd_en & empty_q;
   end

   // RAM port kept reset-free so it maps onto block RAM with its output register
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr_q] <= wr_data;
      if (ram_rd) ram_dout <= mem[rptr_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

`ifdef DRM_SYNC_FIFO_FWFT_EN
   // Head word lives in out_data_q, the next one in ram_dout (stage); empty tracks out_data_q.
   logic                  stg_valid_q, stg_valid_d, out_load, out_valid;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]      ram_cnt;

   always_comb begin
      out_valid   = !empty_q;
      out_load    = stg_valid_q & (empty_q | rd_acc);
      ram_cnt     = count_q - CNT_W'(out_valid) - CNT_W'(stg_valid_q);
      ram_rd      = (ram_cnt != '0) & (~stg_valid_q | out_load);
      rptr_d      = rptr_q + ADDR_WIDTH'(ram_rd);
      stg_valid_d = ram_rd | (stg_valid_q & ~out_load);
      empty_d     = ~(out_load | (out_valid & ~rd_acc));
      out_data_d  = out_load ? ram_dout : out_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         stg_valid_q <= stg_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign rd_data  = out_data_q;
   assign rd_valid = !empty_q;
`else
   // dvalid_q masks the unreset RAM output until the first read after reset
   logic rd_valid_q, rd_valid_d, dvalid_q, dvalid_d;

   always_comb begin
      ram_rd     = rd_acc;
      rptr_d     = rptr_q + ADDR_WIDTH'(rd_acc);
      empty_d    = (count_d == '0);
      rd_valid_d = rd_acc;
      dvalid_d   = dvalid_q | rd_acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         dvalid_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         dvalid_q   <= dvalid_d;
      end
   end

   assign rd_data  = dvalid_q ? ram_dout : '0;
   assign rd_valid = rd_valid_q;
`endif

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_drm_sync_fifo.sv
// tb_drm_sync_fifo: scoreboard bench for drm_sync_fifo (DATA_WIDTH=18, ADDR_WIDTH=4, AFULL_TH=14).
module tb_drm_sync_fifo;
   localparam int DW    = 18;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AFT   = 14;
   localparam int AET   = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [AW:0]   count;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb[$];
   int            m_cnt = 0;
   logic          exp_rv, exp_ovf, exp_unf;

   always #5 clk = ~clk;

   drm_sync_fifo #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AFULL_TH  (AFT),
      .AEMPTY_TH (AET)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   // Drives one clock of stimulus and advances the reference model; returns at posedge+1.
   task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
      logic wacc, racc;
      wr_en = we; wr_data = wd; rd_en = re;
      wacc    = we && (m_cnt < DEPTH);
      racc    = re && (m_cnt > 0);
      exp_ovf = we && (m_cnt == DEPTH);
      exp_unf = re && (m_cnt == 0);
      exp_rv  = racc;
      if (wacc) sb.push_back(wd);
      m_cnt = m_cnt + int'(wacc) - int'(racc);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset;
      logic [11:0] got, want;
      repeat (2) @(posedge clk);
      #1;
      got  = {count, empty, almost_empty, full, almost_full, rd_valid, overflow, underflow};
      want = {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin errors++; $display("FAIL reset_flags got %h exp %h", got, want); end
      checks++;
      if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
      rst_n = 1'b1;
      m_cnt = 0;
      sb.delete();
   endtask

   task automatic test_basic;
      logic [DW-1:0] e;
      for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b0, '0, 1'b1);
         checks++;
         if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rv got %b exp 1", rd_valid); end
         e = DW'(i);
         void'(sb.pop_front());
         checks++;
         if (rd_data !== e) begin errors++; $display("FAIL basic_data got %h exp %h", rd_data, e); end
      end
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rv_idle got %b exp 0", rd_valid); end
      checks++;
      if (count !== '0 || empty !== 1'b1)
         begin errors++; $display("FAIL basic_end got cnt=%0d empty=%b exp cnt=0 empty=1", count, empty); end
   endtask

   task automatic test_fill;
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b1, DW'(32'h200 + i), 1'b0);
         checks++;
         if (count !== (AW+1)'(m_cnt) || almost_full !== (m_cnt >= AFT) || full !== (m_cnt == DEPTH)
             || almost_empty !== (m_cnt <= AET))
            begin errors++; $display("FAIL fill_%0d got cnt=%0d af=%b f=%b ae=%b exp cnt=%0d", i, count,
                                     almost_full, full, almost_empty, m_cnt); end
      end
      cycle(1'b1, DW'(32'h3ABCD), 1'b0);
      checks++;
      if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1)
         begin errors++; $display("FAIL overflow got ovf=%b cnt=%0d exp ovf=1 cnt=16", overflow, count); end
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (overflow !== 1'b0 || count !== 5'd16)
         begin errors++; $display("FAIL overflow_pulse got ovf=%b cnt=%0d exp ovf=0 cnt=16", overflow, count); end
   endtask

   task automatic test_simultaneous;
      logic [DW-1:0] e;
      cycle(1'b1, DW'(32'h3FFFF), 1'b1);
      checks++;
      if (count !== 5'd15 || overflow !== 1'b1 || rd_valid !== 1'b1 || underflow !== 1'b0)
         begin errors++; $display("FAIL full_rw got cnt=%0d ovf=%b rv=%b exp cnt=15 ovf=1 rv=1", count, overflow,
                                  rd_valid); end
      e = sb.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("FAIL full_rw_data got %h exp %h", rd_data, e); end
      for (int i = 0; i < DEPTH && m_cnt > 0; i++) begin
         cycle(1'b0, '0, 1'b1);
         checks++;
         if (rd_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL drain_rv got %b exp 1", rd_valid);
         end else begin
            e = sb.pop_front();
            if (rd_data !== e) begin errors++; $display("FAIL drain_data got %h exp %h", rd_data, e); end
         end
      end
      cycle(1'b1, DW'(32'h155), 1'b1);
      checks++;
      if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || empty !== 1'b0)
         begin errors++; $display("FAIL empty_rw got cnt=%0d unf=%b rv=%b exp cnt=1 unf=1 rv=0", count, underflow,
                                  rd_valid); end
      cycle(1'b0, '0, 1'b1);
      void'(sb.pop_front());
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 18'h00155 || underflow !== 1'b0)
         begin errors++; $display("FAIL empty_rw_data got %h rv=%b exp 00155 rv=1", rd_data, rd_valid); end
   endtask

   task automatic test_stream;
      int   wi, ri;
      logic started;
      logic [DW-1:0] e;
      wi = 0; ri = 0; started = 1'b0;
      for (int cyc = 0; cyc < 200 && ri < 40; cyc++) begin
         if (m_cnt >= 8) started = 1'b1;
         cycle(wi < 40, DW'(wi), started && m_cnt > 0);
         if (exp_rv || (wi < 40 && m_cnt <= DEPTH)) wi = (wi < 40) ? wi + 1 : wi;
         checks++;
         if (rd_valid !== exp_rv || count !== (AW+1)'(m_cnt) || almost_empty !== (m_cnt <= AET))
            begin errors++; $display("FAIL stream_flags got rv=%b cnt=%0d ae=%b exp rv=%b cnt=%0d", rd_valid, count,
                                     almost_empty, exp_rv, m_cnt); end
         if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL stream_extra got %h exp none", rd_data);
            end else begin
               e = sb.pop_front();
               if (rd_data !== e || rd_data !== DW'(ri))
                  begin errors++; $display("FAIL stream_data got %h exp %h", rd_data, DW'(ri)); end
            end
            ri++;
         end
      end
      checks++;
      if (ri != 40 || empty !== 1'b1)
         begin errors++; $display("FAIL stream_total got %0d empty=%b exp 40 empty=1", ri, empty); end
   endtask

   task automatic test_reset_midstream;
      logic [11:0] got, want;
      for (int i = 0; i < 10; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0);
      cycle(1'b0, '0, 1'b1);
      checks++;
      if (count !== 5'd9 || rd_valid !== 1'b1 || rd_data !== 18'h00100)
         begin errors++; $display("FAIL pre_reset got cnt=%0d rv=%b d=%h exp cnt=9 rv=1 d=00100", count, rd_valid,
                                  rd_data); end
      #3 rst_n = 1'b0;
      #1;
      got  = {count, empty, almost_empty, full, almost_full, rd_valid, overflow, underflow};
      want = {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want || rd_data !== '0)
         begin errors++; $display("FAIL async_reset got %h d=%h exp %h d=0", got, rd_data, want); end
      sb.delete();
      m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, DW'(32'h2AAAA), 1'b0);
      cycle(1'b0, '0, 1'b1);
      void'(sb.pop_front());
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 18'h2AAAA || count !== '0)
         begin errors++; $display("FAIL post_reset got d=%h rv=%b cnt=%0d exp 2aaaa rv=1 cnt=0", rd_data, rd_valid,
                                  count); end
   endtask

   task automatic test_fwft;
      logic [DW-1:0] e;
      wr_en = 1'b1; wr_data = 18'h12345;
      @(posedge clk); #1;
      wr_en = 1'b0;
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL fwft_n0 got empty=%b exp 1", empty); end
      @(posedge clk); #1;
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL fwft_n1 got empty=%b exp 1", empty); end
      @(posedge clk); #1;
      checks++;
      if (empty !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 18'h12345 || count !== 5'd1)
         begin errors++; $display("FAIL fwft_n2 got e=%b d=%h cnt=%0d exp e=0 d=12345 cnt=1", empty, rd_data,
                                  count); end
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      checks++;
      if (empty !== 1'b1 || count !== '0)
         begin errors++; $display("FAIL fwft_pop got e=%b cnt=%0d exp e=1 cnt=0", empty, count); end
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = DW'(32'h300 + i); sb.push_back(wr_data);
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         e = sb.pop_front();
         checks++;
         if (empty !== 1'b0 || rd_data !== e)
            begin errors++; $display("FAIL fwft_b2b got e=%b d=%h exp e=0 d=%h", empty, rd_data, e); end
         rd_en = 1'b1;
         @(posedge clk); #1;
      end
      rd_en = 1'b0;
      checks++;
      if (empty !== 1'b1 || count !== '0)
         begin errors++; $display("FAIL fwft_drain got e=%b cnt=%0d exp e=1 cnt=0", empty, count); end
   endtask

   initial begin
      test_reset();
`ifdef DRM_SYNC_FIFO_FWFT_EN
      test_fwft();
`else
      test_basic();
      test_fill();
      test_simultaneous();
      test_stream();
      test_reset_midstream();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
